// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA raster timing block: 640x480@60 defaults,
// the totals and sync windows derived from them, and the position width.
package vga_timing_pkg;

   localparam int POS_W = 10;

   localparam int H_DISPLAY_DEF = 640;
   localparam int H_FRONT_DEF   = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BACK_DEF    = 48;
   localparam int V_DISPLAY_DEF = 480;
   localparam int V_FRONT_DEF   = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BACK_DEF    = 33;

   // Length of one axis (pixels per line or lines per frame).
   function automatic int axis_total(input int display, input int front,
                                     input int sync, input int back);
      return display + front + sync + back;
   endfunction

   localparam int H_TOTAL_DEF      = axis_total(H_DISPLAY_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
   localparam int V_TOTAL_DEF      = axis_total(V_DISPLAY_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);
   localparam int H_SYNC_START_DEF = H_DISPLAY_DEF + H_FRONT_DEF;
   localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
   localparam int V_SYNC_START_DEF = V_DISPLAY_DEF + V_FRONT_DEF;
   localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle between the timing generator (master) and the
// pattern / pin logic that consumes it (slave).
// pix_en is a plain pixel-advance enable, not a handshake: the master steps
// its counters on every clk edge where pix_en is high and never stalls it.
interface vga_timing_if #(
   parameter int FRAME_W = 9
);
   logic                             pix_en;
   logic [vga_timing_pkg::POS_W-1:0] hpos;
   logic [vga_timing_pkg::POS_W-1:0] vpos;
   logic                             hsync;
   logic                             vsync;
   logic                             display_on;
   logic                             line_start;
   logic                             frame_start;
   logic [FRAME_W-1:0]               frame_no;

   modport master (
      input  pix_en,
      output hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_no
   );

   modport slave (
      output pix_en,
      input  hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_no
   );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus registered visible-area
// and sync-window decodes. The decodes are taken from the next count so they
// line up with the registered count in the same cycle.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int DISPLAY = H_DISPLAY_DEF,
   parameter int FRONT   = H_FRONT_DEF,
   parameter int SYNC    = H_SYNC_DEF,
   parameter int BACK    = H_BACK_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             step,
   output logic [POS_W-1:0] count,
   output logic             wrap_next,
   output logic             active,
   output logic             sync_on
);

   localparam int TOTAL      = axis_total(DISPLAY, FRONT, SYNC, BACK);
   localparam int SYNC_START = DISPLAY + FRONT;
   localparam int SYNC_END   = SYNC_START + SYNC;

   generate
      if (TOTAL > (1 << POS_W) || TOTAL < 1) begin : g_bad_total
         $error("vga_axis_counter: axis total %0d does not fit a %0d-bit counter", TOTAL, POS_W);
      end
   endgenerate

   // One spare bit so a window end equal to 2^POS_W still compares correctly.
   typedef logic [POS_W:0] cmp_t;

   localparam logic [POS_W-1:0] LAST   = POS_W'(TOTAL - 1);
   localparam cmp_t             DISP_C = cmp_t'(DISPLAY);
   localparam cmp_t             SS_C   = cmp_t'(SYNC_START);
   localparam cmp_t             SE_C   = cmp_t'(SYNC_END);

   // Decode values for count == 0, which is where reset leaves the axis.
   localparam logic ACTIVE_RST = (DISPLAY > 0);
   localparam logic SYNC_RST   = (SYNC_START == 0) && (SYNC > 0);

   logic [POS_W-1:0] count_nxt;
   cmp_t             nxt_ext;
   logic             at_last;

   // Next count: hold, increment, or wrap to zero at the end of the axis.
   always_comb begin
      at_last   = (count == LAST);
      wrap_next = step && at_last;
      count_nxt = count;
      if (step) begin
         count_nxt = at_last ? '0 : count + 1'b1;
      end
      nxt_ext = {1'b0, count_nxt};
   end

   // Register the count together with decodes of its next value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count   <= '0;
         active  <= ACTIVE_RST;
         sync_on <= SYNC_RST;
      end else begin
         count   <= count_nxt;
         active  <= (nxt_ext < DISP_C);
         sync_on <= (nxt_ext >= SS_C) && (nxt_ext < SE_C);
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: horizontal and vertical axis counters chained
// through the line wrap, registered sync / visible / strobe outputs, and a
// frame counter clocked from clk rather than from any sync edge.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_DISPLAY       = H_DISPLAY_DEF,
   parameter int H_FRONT         = H_FRONT_DEF,
   parameter int H_SYNC          = H_SYNC_DEF,
   parameter int H_BACK          = H_BACK_DEF,
   parameter int V_DISPLAY       = V_DISPLAY_DEF,
   parameter int V_FRONT         = V_FRONT_DEF,
   parameter int V_SYNC          = V_SYNC_DEF,
   parameter int V_BACK          = V_BACK_DEF,
   parameter int SYNC_ACTIVE_LOW = 1,
   parameter int FRAME_W         = 9
) (
   input  logic         clk,
   input  logic         rst_n,
   vga_timing_if.master tim
);

   localparam int H_TOTAL = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
   localparam int V_TOTAL = axis_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

   generate
      if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
         $error("vga_timing_gen: H_TOTAL %0d / V_TOTAL %0d exceed 1024", H_TOTAL, V_TOTAL);
      end
   endgenerate

   // Inverting a registered flag by a constant keeps the output glitch-free.
   localparam logic SYNC_INV = (SYNC_ACTIVE_LOW != 0);

   logic [POS_W-1:0]   h_count;
   logic [POS_W-1:0]   v_count;
   logic               h_wrap;
   logic               v_wrap;
   logic               h_active;
   logic               v_active;
   logic               h_sync_on;
   logic               v_sync_on;
   logic               line_start_q;
   logic               frame_start_q;
   logic [FRAME_W-1:0] frame_q;

   vga_axis_counter #(
      .DISPLAY (H_DISPLAY),
      .FRONT   (H_FRONT),
      .SYNC    (H_SYNC),
      .BACK    (H_BACK)
   ) u_h_axis (
      .clk       (clk),
      .rst_n     (rst_n),
      .step      (tim.pix_en),
      .count     (h_count),
      .wrap_next (h_wrap),
      .active    (h_active),
      .sync_on   (h_sync_on)
   );

   // The vertical axis advances only on the cycle the line wraps, so vsync
   // and the vertical decodes change exactly on the hpos wrap.
   vga_axis_counter #(
      .DISPLAY (V_DISPLAY),
      .FRONT   (V_FRONT),
      .SYNC    (V_SYNC),
      .BACK    (V_BACK)
   ) u_v_axis (
      .clk       (clk),
      .rst_n     (rst_n),
      .step      (h_wrap),
      .count     (v_count),
      .wrap_next (v_wrap),
      .active    (v_active),
      .sync_on   (v_sync_on)
   );

   // Strobes mark the cycle the position has just become (0,*) / (0,0);
   // the frame count advances in that same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_q       <= '0;
      end else begin
         line_start_q  <= h_wrap;
         frame_start_q <= v_wrap;
         if (v_wrap) begin
            frame_q <= frame_q + 1'b1;
         end
      end
   end

   assign tim.hpos        = h_count;
   assign tim.vpos        = v_count;
   assign tim.hsync       = h_sync_on ^ SYNC_INV;
   assign tim.vsync       = v_sync_on ^ SYNC_INV;
   assign tim.display_on  = h_active & v_active;
   assign tim.line_start  = line_start_q;
   assign tim.frame_start = frame_start_q;
   assign tim.frame_no    = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance for line-level timing
// and mid-line reset, plus a tiny-raster active-high-sync instance so many
// frames (and the frame counter wrap) fit in a short run. Expected outputs
// come from the count of enabled steps since reset, using division/modulo.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a;
   logic rst_b;

   vga_timing_if #(.FRAME_W(9)) bus_a ();
   vga_timing_if #(.FRAME_W(3)) bus_b ();

   vga_timing_gen dut_a (
      .clk   (clk),
      .rst_n (rst_a),
      .tim   (bus_a)
   );

   vga_timing_gen #(
      .H_DISPLAY       (8),
      .H_FRONT         (2),
      .H_SYNC          (3),
      .H_BACK          (3),
      .V_DISPLAY       (4),
      .V_FRONT         (1),
      .V_SYNC          (2),
      .V_BACK          (2),
      .SYNC_ACTIVE_LOW (0),
      .FRAME_W         (3)
   ) dut_b (
      .clk   (clk),
      .rst_n (rst_b),
      .tim   (bus_b)
   );

   int     checks = 0;
   int     errors = 0;
   longint na = 0;
   longint nb = 0;

   typedef struct {
      int h;
      int v;
      int f;
      bit hs;
      bit vs;
      bit de;
   } exp_t;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Raster position after n enabled pixel steps from reset.
   function automatic exp_t model(input longint n, input int hd, input int hf, input int hsw,
                                  input int hb, input int vd, input int vf, input int vsw,
                                  input int vb, input int fw, input bit act_low);
      exp_t e;
      int ht, vt;
      bit hin, vin;
      ht   = hd + hf + hsw + hb;
      vt   = vd + vf + vsw + vb;
      e.h  = int'(n % ht);
      e.v  = int'((n / ht) % vt);
      e.f  = int'((n / (ht * vt)) % (64'd1 << fw));
      hin  = (e.h >= hd + hf) && (e.h < hd + hf + hsw);
      vin  = (e.v >= vd + vf) && (e.v < vd + vf + vsw);
      e.hs = act_low ? !hin : hin;
      e.vs = act_low ? !vin : vin;
      e.de = (e.h < hd) && (e.v < vd);
      return e;
   endfunction

   task automatic check_a(input bit stepped);
      exp_t e;
      e = model(na, 640, 16, 96, 48, 480, 10, 2, 33, 9, 1'b1);
      chk("a_hpos",        32'(bus_a.hpos),        32'(e.h));
      chk("a_vpos",        32'(bus_a.vpos),        32'(e.v));
      chk("a_hsync",       32'(bus_a.hsync),       32'(e.hs));
      chk("a_vsync",       32'(bus_a.vsync),       32'(e.vs));
      chk("a_display_on",  32'(bus_a.display_on),  32'(e.de));
      chk("a_line_start",  32'(bus_a.line_start),  32'(stepped && e.h == 0 && na > 0));
      chk("a_frame_start", 32'(bus_a.frame_start), 32'(stepped && e.h == 0 && e.v == 0 && na > 0));
      chk("a_frame_no",    32'(bus_a.frame_no),    32'(e.f));
   endtask

   task automatic check_b(input bit stepped);
      exp_t e;
      e = model(nb, 8, 2, 3, 3, 4, 1, 2, 2, 3, 1'b0);
      chk("b_hpos",        32'(bus_b.hpos),        32'(e.h));
      chk("b_vpos",        32'(bus_b.vpos),        32'(e.v));
      chk("b_hsync",       32'(bus_b.hsync),       32'(e.hs));
      chk("b_vsync",       32'(bus_b.vsync),       32'(e.vs));
      chk("b_display_on",  32'(bus_b.display_on),  32'(e.de));
      chk("b_line_start",  32'(bus_b.line_start),  32'(stepped && e.h == 0 && nb > 0));
      chk("b_frame_start", 32'(bus_b.frame_start), 32'(stepped && e.h == 0 && e.v == 0 && nb > 0));
      chk("b_frame_no",    32'(bus_b.frame_no),    32'(e.f));
   endtask

   // Apply pix_en for one clk edge, then sample 1 time unit after the edge.
   task automatic cycle_a(input bit en);
      bus_a.pix_en = en;
      @(posedge clk);
      #1;
      if (en) na++;
      check_a(en);
   endtask

   task automatic cycle_b(input bit en);
      bus_b.pix_en = en;
      @(posedge clk);
      #1;
      if (en) nb++;
      check_b(en);
   endtask

   initial begin
      int ls_cnt;
      int first_ls;
      int fs_cnt;
      int cyc;
      bit wrapped;

      rst_a        = 1'b0;
      rst_b        = 1'b0;
      bus_a.pix_en = 1'b0;
      bus_b.pix_en = 1'b0;

      // Reset state of both instances.
      repeat (3) @(posedge clk);
      #1;
      check_a(1'b0);
      check_b(1'b0);
      chk("b_reset_hsync_idle_low", 32'(bus_b.hsync), 32'd0);

      // Continuous pix_en over two full lines: hsync/display edges and wraps.
      rst_a  = 1'b1;
      ls_cnt = 0;
      for (int i = 0; i < 1700; i++) begin
         cycle_a(1'b1);
         if (bus_a.line_start) ls_cnt++;
      end
      chk("a_line_starts_in_1700", 32'(ls_cnt), 32'd2);

      // Random pix_en, including strict 1,0 alternation.
      for (int i = 0; i < 200; i++) cycle_a(1'(i % 2 == 0));
      for (int i = 0; i < 400; i++) cycle_a(1'($urandom_range(0, 1)));

      // Asynchronous reset mid-line, between clock edges, with pix_en high.
      bus_a.pix_en = 1'b1;
      #2;
      rst_a = 1'b0;
      #1;
      na = 0;
      check_a(1'b0);
      @(posedge clk);
      #1;
      check_a(1'b0);
      rst_a = 1'b1;

      // First line_start after release lands on the 800th enabled cycle.
      first_ls = -1;
      for (int i = 1; i <= 820; i++) begin
         cycle_a(1'b1);
         if (bus_a.line_start && first_ls < 0) first_ls = i;
      end
      chk("a_first_line_start_after_reset", 32'(first_ls), 32'd800);
      bus_a.pix_en = 1'b0;

      // Tiny raster: many frames with random pix_en, through frame_no wrap.
      rst_b   = 1'b1;
      fs_cnt  = 0;
      wrapped = 1'b0;
      cyc     = 0;
      while (nb < 144 * 9 + 40 && cyc < 6000) begin
         cycle_b(1'($urandom_range(0, 3) != 0));
         cyc++;
         if (bus_b.frame_start) begin
            fs_cnt++;
            if (bus_b.frame_no == 3'd0) wrapped = 1'b1;
         end
      end
      chk("b_step_budget", 32'(nb >= 144 * 9 + 40), 32'd1);
      chk("b_frame_start_count", 32'(fs_cnt), 32'(nb / 144));
      chk("b_frame_no_wrap_seen", 32'(wrapped), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
